fccc_ngmux_ctrl: RTL and testbench
==================================

FCCC_NGMUX_CTRL -- requirements
Module: fccc_ngmux_ctrl

Interface
REQ-001 Parameter HOLD_CYC, default 4, cycles HOLD_N is held low before SEL changes (range 1..255).
REQ-002 Parameter SETTLE_CYC, default 8, cycles after the SEL change before HOLD_N is released (range 1..255).
REQ-003 Parameter ARST_CYC, default 4, cycles ARST_N is held low on lock loss (range 1..255).
REQ-004 Parameter LOCK_FILT_CYC, default 64, consecutive synchronised-high LOCK cycles required for LOCK_OK (range 1..255).
REQ-005 CLK  in  1  single block clock; all logic is on its rising edge.
REQ-006 RESET  in  1  asynchronous, active-high reset.
REQ-007 LOCK  in  1  PLL lock from the FCCC, asynchronous to CLK.
REQ-008 SW_REQ  in  2  per-channel switch request (bit n = channel n), level, held until SW_ACK.
REQ-009 SW_SEL  in  2  per-channel target select, 0=CLK0 side, 1=CLK1 side; stable while SW_REQ is high.
REQ-010 SW_ACK  out  2  per-channel one-cycle completion pulse.
REQ-011 BUSY  out  2  per-channel high in any state other than IDLE.
REQ-012 LOCK_OK  out  1  filtered, synchronised lock status.
REQ-013 NGMUX0_SEL, NGMUX0_HOLD_N, NGMUX0_ARST_N  out  1 each  channel-0 NGMUX controls.
REQ-014 NGMUX1_SEL, NGMUX1_HOLD_N, NGMUX1_ARST_N  out  1 each  channel-1 NGMUX controls.

Function
REQ-015 Each channel has an independent FSM with states IDLE, HOLD, SWITCH, RELEASE and ARST; the two channels never interact.
REQ-016 IDLE: SW_REQ=1 and LOCK_OK=1 in cycle N -> accept; SW_REQ is ignored while LOCK_OK=0 and is not latched.
REQ-017 If SW_SEL equals the current SEL on accept, the channel pulses SW_ACK in cycle N+1, holds HOLD_N high and stays in IDLE.
REQ-018 Otherwise HOLD is entered at N+1 with HOLD_N=0 for HOLD_CYC cycles.
REQ-019 SWITCH: SEL takes SW_SEL in the first SWITCH cycle, HOLD_N stays 0, and the state lasts SETTLE_CYC cycles.
REQ-020 RELEASE: lasts one cycle with HOLD_N=1 and SW_ACK=1, then IDLE; SW_ACK is in cycle N+1+HOLD_CYC+SETTLE_CYC (N+13 at defaults).
REQ-021 A LOCK_OK falling edge from any state -> ARST, overriding all other events in that cycle.
REQ-022 ARST: ARST_N=0, HOLD_N=1, SEL=0 for ARST_CYC cycles, then IDLE; an aborted switch produces no SW_ACK.
REQ-023 A request held through ARST is re-evaluated in IDLE under REQ-016.
REQ-024 Counters are CNT_W=8 bits, load N-1 on state entry and decrement to 0 without wrap.
REQ-025 LOCK is synchronised by 2 flops; LOCK_OK per REQ-031/REQ-032 and falls in the cycle the synchronised LOCK is low.

Reset
REQ-026 RESET=1 forces the following: FSMs to IDLE, all counters 0, LOCK_OK=0, SW_ACK=0, BUSY=0.
REQ-027 During RESET=1 the NGMUX outputs are SEL=0, HOLD_N=1, ARST_N=0; the first cycle after release has ARST_N=1.
REQ-028 Reset asserted mid-switch aborts it immediately with no SW_ACK.
REQ-029 The LOCK synchroniser flops reset to 0.

Configuration
REQ-030 Macro FCCC_NGMUX_LOCK_FILT_EN selects the lock filter.
REQ-031 With FCCC_NGMUX_LOCK_FILT_EN defined, LOCK_OK rises only after LOCK_FILT_CYC consecutive synchronised-high cycles; any low sample clears the count.
REQ-032 Without FCCC_NGMUX_LOCK_FILT_EN, LOCK_OK equals the 2-flop synchronised LOCK, LOCK_FILT_CYC is unused and no filter counter is built.

Structure
REQ-033 Shared package fccc_ngmux_pkg holds the FSM state enum ngmux_state_t (IDLE, HOLD, SWITCH, RELEASE, ARST), CNT_W=8 and the parameter default constants.
REQ-034 Sub-module fccc_ngmux_chan implements one channel FSM and its counter and is instantiated twice.
REQ-035 The synchroniser and lock filter stay in the top level.

Verification
REQ-036 LOCK=1 constant, filter on -> LOCK_OK rises 2+64 cycles after LOCK rises; LOCK toggled low once at cycle 30 -> count restarts.
REQ-037 LOCK_OK=1, SW_REQ[0]=1, SW_SEL[0]=1 at cycle N -> HOLD_N0 low N+1..N+12, SEL0=1 at N+5, SW_ACK[0] and HOLD_N0=1 at N+13.
REQ-038 SW_SEL[1]=0 equal to current SEL1 -> SW_ACK[1] at N+1 and HOLD_N1 never low.
REQ-039 LOCK drops at accept+6 -> ARST_N0=0 for 4 cycles, SEL0=0, no SW_ACK[0], BUSY[0] low after ARST.
REQ-040 Both channels requested in the same cycle -> both SW_ACK in the same cycle N+13; SW_REQ with LOCK_OK=0 -> no response until LOCK_OK rises.
REQ-041 RESET asserted in SWITCH -> outputs match REQ-027 immediately (asynchronously), no SW_ACK.

Source files
------------

// File: rtl/fccc_ngmux_pkg.sv
// Shared types and constants for the FCCC NGMUX switch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fccc_ngmux_pkg;

    localparam int CNT_W             = 8;
    localparam int HOLD_CYC_DEF      = 4;
    localparam int SETTLE_CYC_DEF    = 8;
    localparam int ARST_CYC_DEF      = 4;
    localparam int LOCK_FILT_CYC_DEF = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD    = 3'd1,
        SWITCH  = 3'd2,
        RELEASE = 3'd3,
        ARST    = 3'd4
    } ngmux_state_t;

    // Counters count down to zero, so an N-cycle state loads N-1 on entry.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/fccc_ngmux_ctrl_if.sv
// Request/acknowledge and NGMUX control bundle of the FCCC NGMUX controller.
// Latency: n/a (wiring only).
// Backpressure: level request held by master until the one-cycle sw_ack.
interface fccc_ngmux_ctrl_if;

    logic       lock;
    logic [1:0] sw_req;
    logic [1:0] sw_sel;
    logic [1:0] sw_ack;
    logic [1:0] busy;
    logic       lock_ok;
    logic       ngmux0_sel;
    logic       ngmux0_hold_n;
    logic       ngmux0_arst_n;
    logic       ngmux1_sel;
    logic       ngmux1_hold_n;
    logic       ngmux1_arst_n;

    modport master (
        output lock, sw_req, sw_sel,
        input  sw_ack, busy, lock_ok,
        input  ngmux0_sel, ngmux0_hold_n, ngmux0_arst_n,
        input  ngmux1_sel, ngmux1_hold_n, ngmux1_arst_n
    );

    modport slave (
        input  lock, sw_req, sw_sel,
        output sw_ack, busy, lock_ok,
        output ngmux0_sel, ngmux0_hold_n, ngmux0_arst_n,
        output ngmux1_sel, ngmux1_hold_n, ngmux1_arst_n
    );

endinterface

// File: rtl/fccc_ngmux_chan.sv
// One NGMUX channel: hold -> switch select -> settle -> release, with lock-loss reset.
// Latency: sw_ack 1 cycle after accept if already selected, else 1+HOLD_CYC+SETTLE_CYC.
// Backpressure: requests only accepted in IDLE with lock_ok high; otherwise left pending.
module fccc_ngmux_chan
    import fccc_ngmux_pkg::*;
#(
    parameter int HOLD_CYC   = HOLD_CYC_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int ARST_CYC   = ARST_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic lock_ok,
    input  logic lock_fall,
    input  logic sw_req,
    input  logic sw_sel,
    output logic sw_ack,
    output logic busy,
    output logic sel,
    output logic hold_n,
    output logic arst_n
);

    ngmux_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sel_q, sel_nxt;
    logic             ack_q, ack_nxt;

    // Next-state logic; lock loss pre-empts whatever the FSM would otherwise do.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel_q;
        ack_nxt   = 1'b0;
        if (lock_fall) begin
            state_nxt = ARST;
            cnt_nxt   = cnt_load(ARST_CYC);
            sel_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // ack_q blocks re-acceptance of a request still high in its ack cycle.
                    if (sw_req && lock_ok && !ack_q) begin
                        if (sw_sel == sel_q) begin
                            ack_nxt = 1'b1;
                        end else begin
                            state_nxt = HOLD;
                            cnt_nxt   = cnt_load(HOLD_CYC);
                        end
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state_nxt = SWITCH;
                        cnt_nxt   = cnt_load(SETTLE_CYC);
                        // A switch only starts when the target differs, so it is ~sel.
                        sel_nxt   = ~sel_q;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                SWITCH: begin
                    if (cnt == '0) begin
                        state_nxt = RELEASE;
                        ack_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                RELEASE: begin
                    state_nxt = IDLE;
                end
                ARST: begin
                    if (cnt == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, counter, select and acknowledge registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sel_q <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sel_q <= sel_nxt;
            ack_q <= ack_nxt;
        end
    end

    assign sw_ack = ack_q;
    assign busy   = (state != IDLE);
    assign sel    = sel_q;
    assign hold_n = !((state == HOLD) || (state == SWITCH));
    // Reset drives the NGMUX reset directly so it asserts without waiting for a clock.
    assign arst_n = !rst && (state != ARST);

endmodule

// File: rtl/fccc_ngmux_ctrl.sv
// Two-channel FCCC NGMUX switch controller with synchronised (optionally filtered) PLL lock.
// Latency: lock_ok 2 cycles after lock (+LOCK_FILT_CYC with FCCC_NGMUX_LOCK_FILT_EN); see channel.
// Backpressure: per-channel level request held until sw_ack; ignored while lock_ok is low.
module fccc_ngmux_ctrl
    import fccc_ngmux_pkg::*;
#(
    parameter int HOLD_CYC      = HOLD_CYC_DEF,
    parameter int SETTLE_CYC    = SETTLE_CYC_DEF,
    parameter int ARST_CYC      = ARST_CYC_DEF,
    parameter int LOCK_FILT_CYC = LOCK_FILT_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    fccc_ngmux_ctrl_if.slave   bus
);

    logic lock_s1, lock_s2;
    logic lock_ok, lock_ok_d, lock_fall;
    logic ack0, ack1, busy0, busy1;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
        end else begin
            lock_s1 <= bus.lock;
            lock_s2 <= lock_s1;
        end
    end

`ifdef FCCC_NGMUX_LOCK_FILT_EN
    logic [CNT_W-1:0] filt_cnt;
    logic             filt_ok;

    // Count consecutive high samples; any low sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_cnt <= '0;
            filt_ok  <= 1'b0;
        end else if (!lock_s2) begin
            filt_cnt <= '0;
            filt_ok  <= 1'b0;
        end else if (filt_cnt == cnt_load(LOCK_FILT_CYC)) begin
            filt_ok <= 1'b1;
        end else begin
            filt_cnt <= filt_cnt + CNT_W'(1);
        end
    end

    // Drop immediately on a low sample rather than one cycle later.
    assign lock_ok = filt_ok & lock_s2;
`else
    assign lock_ok = lock_s2;

    // The filter length has no effect in this build.
    logic [CNT_W-1:0] unused_filt_cyc;
    assign unused_filt_cyc = CNT_W'(LOCK_FILT_CYC);
`endif

    // Delayed lock_ok for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_ok_d <= 1'b0;
        end else begin
            lock_ok_d <= lock_ok;
        end
    end

    assign lock_fall   = lock_ok_d & ~lock_ok;
    assign bus.lock_ok = lock_ok;

    fccc_ngmux_chan #(
        .HOLD_CYC   (HOLD_CYC),
        .SETTLE_CYC (SETTLE_CYC),
        .ARST_CYC   (ARST_CYC)
    ) u_chan0 (
        .clk       (clk),
        .rst       (rst),
        .lock_ok   (lock_ok),
        .lock_fall (lock_fall),
        .sw_req    (bus.sw_req[0]),
        .sw_sel    (bus.sw_sel[0]),
        .sw_ack    (ack0),
        .busy      (busy0),
        .sel       (bus.ngmux0_sel),
        .hold_n    (bus.ngmux0_hold_n),
        .arst_n    (bus.ngmux0_arst_n)
    );

    fccc_ngmux_chan #(
        .HOLD_CYC   (HOLD_CYC),
        .SETTLE_CYC (SETTLE_CYC),
        .ARST_CYC   (ARST_CYC)
    ) u_chan1 (
        .clk       (clk),
        .rst       (rst),
        .lock_ok   (lock_ok),
        .lock_fall (lock_fall),
        .sw_req    (bus.sw_req[1]),
        .sw_sel    (bus.sw_sel[1]),
        .sw_ack    (ack1),
        .busy      (busy1),
        .sel       (bus.ngmux1_sel),
        .hold_n    (bus.ngmux1_hold_n),
        .arst_n    (bus.ngmux1_arst_n)
    );

    assign bus.sw_ack = {ack1, ack0};
    assign bus.busy   = {busy1, busy0};

endmodule

// File: tb/tb_fccc_ngmux_ctrl.sv
// Directed bench for fccc_ngmux_ctrl: reset, lock sync/filter, switch vector tables, aborts.
// Latency: expectations use default parameters (4/8/4, filter 64 when enabled).
// Backpressure: requests held until sw_ack, then dropped, as a real requester would.
module tb_fccc_ngmux_ctrl;

`ifdef FCCC_NGMUX_LOCK_FILT_EN
    localparam int FILT = 64;
`else
    localparam int FILT = 0;
`endif

    // Observed vector: {ack[1:0], busy[1:0], sel1, sel0, hold1_n, hold0_n, arst1_n, arst0_n}
    typedef struct packed {
        logic [1:0] req;
        logic [1:0] ssel;
        logic [9:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    vec_t tbl [30];
    int   first, rises, last_rise;
    logic prev_ok;
    int   first_arst, arst_lo, ack_seen, first_busy, first_ack;

    fccc_ngmux_ctrl_if bus ();

    fccc_ngmux_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] obs();
        return {bus.sw_ack, bus.busy, bus.ngmux1_sel, bus.ngmux0_sel,
                bus.ngmux1_hold_n, bus.ngmux0_hold_n, bus.ngmux1_arst_n, bus.ngmux0_arst_n};
    endfunction

    function automatic vec_t mk(input logic [1:0] req, input logic [1:0] ssel,
                                input logic [1:0] ack, input logic [1:0] busy,
                                input logic [1:0] selo, input logic [1:0] holdo);
        vec_t v;
        v.req  = req;
        v.ssel = ssel;
        v.exp  = {ack, busy, selo, holdo, 2'b11};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // Table 1: ch0 switches 0->1, ch1 asks for its current select (0).
        tbl[0] = mk(2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11);
        tbl[1] = mk(2'b11, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10);
        for (int i = 2; i <= 4; i++)  tbl[i] = mk(2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10);
        for (int i = 5; i <= 12; i++) tbl[i] = mk(2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b10);
        tbl[13] = mk(2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11);
        tbl[14] = mk(2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b11);
        // Table 2: both channels switch in the same cycle (ch0 1->0, ch1 0->1).
        tbl[15] = mk(2'b11, 2'b10, 2'b00, 2'b00, 2'b01, 2'b11);
        for (int i = 16; i <= 19; i++) tbl[i] = mk(2'b11, 2'b10, 2'b00, 2'b11, 2'b01, 2'b00);
        for (int i = 20; i <= 27; i++) tbl[i] = mk(2'b11, 2'b10, 2'b00, 2'b11, 2'b10, 2'b00);
        tbl[28] = mk(2'b11, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11);
        tbl[29] = mk(2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b11);

        // Reset state, then first cycle after release.
        bus.lock   = 1'b0;
        bus.sw_req = 2'b00;
        bus.sw_sel = 2'b00;
        rst        = 1'b1;
        repeat (3) next_cyc();
        @(negedge clk);
        check("reset_outputs", 32'(obs()), 32'(10'b00_00_00_11_00));
        check("reset_lock_ok", 32'(bus.lock_ok), 32'd0);
        next_cyc();
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_outputs", 32'(obs()), 32'(10'b00_00_00_11_11));
        next_cyc();

        // Lock rise latency.
        bus.lock = 1'b1;
        first = -1;
        for (int c = 0; c < FILT + 8; c++) begin
            @(negedge clk);
            if (bus.lock_ok && first < 0) first = c;
            next_cyc();
        end
        check("lock_ok_rise", 32'(first), 32'(2 + FILT));

        // Lock low for one cycle at cycle 30 restarts the qualification.
        bus.lock = 1'b0;
        repeat (10) next_cyc();
        bus.lock  = 1'b1;
        rises     = 0;
        last_rise = -1;
        prev_ok   = 1'b0;
        for (int c = 0; c < 31 + 2 + FILT + 5; c++) begin
            if (c == 30) bus.lock = 1'b0;
            if (c == 31) bus.lock = 1'b1;
            @(negedge clk);
            if (bus.lock_ok && !prev_ok) begin
                rises++;
                last_rise = c;
            end
            prev_ok = bus.lock_ok;
            next_cyc();
        end
        check("lock_glitch_last_rise", 32'(last_rise), 32'(33 + FILT));
        check("lock_glitch_rises", 32'(rises), (FILT > 0) ? 32'd1 : 32'd2);
        repeat (10) next_cyc();

        // Table-driven switch sequences.
        for (int i = 0; i < 30; i++) begin
            bus.sw_req = tbl[i].req;
            bus.sw_sel = tbl[i].ssel;
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
            next_cyc();
        end

        // Lock lost at accept+6 aborts ch0's switch (sel0=0, sel1=1 here).
        bus.sw_req = 2'b01;
        bus.sw_sel = 2'b11;
        first_arst = -1;
        arst_lo    = 0;
        ack_seen   = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 6) bus.lock = 1'b0;
            @(negedge clk);
            if (c == 8) begin
                check("abort_sel0_switching", 32'(bus.ngmux0_sel), 32'd1);
                check("abort_hold0_switching", 32'(bus.ngmux0_hold_n), 32'd0);
            end
            if (c == 9) begin
                check("abort_sel0_arst", 32'(bus.ngmux0_sel), 32'd0);
                check("abort_hold0_arst", 32'(bus.ngmux0_hold_n), 32'd1);
            end
            if (c == 13) check("abort_busy0_after", 32'(bus.busy[0]), 32'd0);
            if (!bus.ngmux0_arst_n) begin
                if (first_arst < 0) first_arst = c;
                arst_lo++;
            end
            if (bus.sw_ack[0]) ack_seen++;
            next_cyc();
        end
        check("abort_arst_start", 32'(first_arst), 32'd9);
        check("abort_arst_len", 32'(arst_lo), 32'd4);
        check("abort_no_ack", 32'(ack_seen), 32'd0);

        // Request held with lock_ok low is served only once lock_ok rises.
        bus.lock   = 1'b1;
        first_busy = -1;
        first_ack  = -1;
        for (int c = 0; c < FILT + 22; c++) begin
            @(negedge clk);
            if (bus.busy[0] && first_busy < 0) first_busy = c;
            if (bus.sw_ack[0] && first_ack < 0) first_ack = c;
            next_cyc();
            if (first_ack >= 0) bus.sw_req[0] = 1'b0;
        end
        check("pending_busy_start", 32'(first_busy), 32'(3 + FILT));
        check("pending_ack", 32'(first_ack), 32'(15 + FILT));
        repeat (3) next_cyc();

        // Reset asserted while ch1 is in SWITCH (sel0=1, sel1=0 here).
        bus.sw_req = 2'b10;
        bus.sw_sel = 2'b11;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 6) check("rst_mid_sel1_switching", 32'(bus.ngmux1_sel), 32'd1);
            next_cyc();
        end
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", 32'(obs()), 32'(10'b00_00_00_11_00));
        check("rst_mid_lock_ok", 32'(bus.lock_ok), 32'd0);
        bus.sw_req = 2'b00;
        repeat (2) next_cyc();
        rst      = 1'b0;
        ack_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.sw_ack != 2'b00) ack_seen++;
            next_cyc();
        end
        check("rst_mid_no_ack", 32'(ack_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
